// File: rtl/qtree_client_pkg.sv
// Shared types and error-bit indices for the quadtree lookup client.
// Struct field widths are fixed here, so the client's width parameters must match them.
package qtree_client_pkg;

  localparam int QC_D_WIDTH   = 16;
  localparam int QC_A_WIDTH   = 14;
  localparam int QC_TAG_WIDTH = 4;

  localparam int ERR_ORPHAN       = 0;
  localparam int ERR_KEY_MISMATCH = 1;
  localparam int ERR_TIMEOUT      = 2;

  typedef struct packed {
    logic [QC_TAG_WIDTH-1:0] tag;
    logic [QC_D_WIDTH-1:0]   key;
  } pending_t;

  typedef struct packed {
    logic [QC_TAG_WIDTH-1:0] tag;
    logic                    match;
    logic [QC_A_WIDTH-1:0]   addr;
    logic [QC_D_WIDTH-1:0]   key;
  } result_t;

endpackage

// File: rtl/qtree_client_fifo.sv
// Synchronous show-ahead FIFO: data_o presents the head entry whenever empty_o is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module qtree_client_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says an entry is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/qtree_lookup_client.sv
// Initiator side of the quadtree lookup interface: issues keys, pairs in-order responses with
// their request tags, and buffers results under a credit scheme. Optional macro: QTREE_CLIENT_TIMEOUT_EN.
module qtree_lookup_client
  import qtree_client_pkg::*;
#(
  parameter int D_WIDTH   = QC_D_WIDTH,
  parameter int A_WIDTH   = QC_A_WIDTH,
  parameter int TAG_WIDTH = QC_TAG_WIDTH,
  parameter int DEPTH     = 8
`ifdef QTREE_CLIENT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [D_WIDTH-1:0]         req_key_i,
  input  logic [TAG_WIDTH-1:0]       req_tag_i,
  output logic                       lookup_en_o,
  output logic [D_WIDTH-1:0]         lookup_data_o,
  input  logic                       lookup_done_i,
  input  logic                       lookup_match_i,
  input  logic [A_WIDTH-1:0]         lookup_addr_i,
  input  logic [D_WIDTH-1:0]         lookup_data_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [TAG_WIDTH-1:0]       res_tag_o,
  output logic                       res_match_o,
  output logic [A_WIDTH-1:0]         res_addr_o,
  output logic [D_WIDTH-1:0]         res_key_o,
  output logic [$clog2(DEPTH):0]     inflight_o,
  output logic [2:0]                 err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  pending_t          pend_in, pend_head;
  result_t           res_in, res_head;
  logic              pend_empty, res_empty;
  logic [CW-1:0]     pend_count, res_count;
  logic [CW-1:0]     inflight_next, res_next;
  logic              accept, done_ok, orphan, res_pop, tmo_hit;

  logic              req_ready_q, req_ready_d;
  logic              lookup_en_q, lookup_en_d;
  logic [D_WIDTH-1:0] lookup_data_q, lookup_data_d;
  logic [2:0]        err_q, err_d;

  // The pending FIFO occupancy is exactly the number of lookups accepted but not yet answered.
  qtree_client_fifo #(.WIDTH($bits(pending_t)), .DEPTH(DEPTH)) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (accept),
    .data_i  (pend_in),
    .pop_i   (done_ok),
    .data_o  (pend_head),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  qtree_client_fifo #(.WIDTH($bits(result_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (done_ok),
    .data_i  (res_in),
    .pop_i   (res_pop),
    .data_o  (res_head),
    .empty_o (res_empty),
    .count_o (res_count)
  );

`ifdef QTREE_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    if (lookup_done_i || pend_count == '0) tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + TW'(1);
    else tmo_d = tmo_q;
    tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Ready is registered from next-state occupancy so it reads 0 during reset and never looks at req_valid_i.
  always_comb begin
    accept        = req_valid_i && req_ready_q;
    done_ok       = lookup_done_i && !pend_empty;
    orphan        = lookup_done_i && pend_empty;
    res_pop       = !res_empty && res_ready_i;
    pend_in       = '{tag: req_tag_i, key: req_key_i};
    res_in        = '{tag: pend_head.tag, match: lookup_match_i,
                      addr: lookup_addr_i, key: pend_head.key};
    inflight_next = pend_count + CW'(accept) - CW'(done_ok);
    res_next      = res_count + CW'(done_ok) - CW'(res_pop);
    req_ready_d   = (inflight_next + res_next) != CW'(DEPTH);
    lookup_en_d   = accept;
    lookup_data_d = accept ? req_key_i : lookup_data_q;
    err_d         = err_q;
    if (orphan) err_d[ERR_ORPHAN] = 1'b1;
    if (done_ok && (lookup_data_i != pend_head.key)) err_d[ERR_KEY_MISMATCH] = 1'b1;
    if (tmo_hit) err_d[ERR_TIMEOUT] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_ready_q   <= 1'b0;
      lookup_en_q   <= 1'b0;
      lookup_data_q <= '0;
      err_q         <= '0;
    end else begin
      req_ready_q   <= req_ready_d;
      lookup_en_q   <= lookup_en_d;
      lookup_data_q <= lookup_data_d;
      err_q         <= err_d;
    end
  end

  // Result fields are masked while empty so stale storage never reaches the outputs.
  assign req_ready_o   = req_ready_q;
  assign lookup_en_o   = lookup_en_q;
  assign lookup_data_o = lookup_data_q;
  assign res_valid_o   = !res_empty;
  assign res_tag_o     = res_empty ? '0 : res_head.tag;
  assign res_match_o   = res_empty ? 1'b0 : res_head.match;
  assign res_addr_o    = res_empty ? '0 : res_head.addr;
  assign res_key_o     = res_empty ? '0 : res_head.key;
  assign inflight_o    = pend_count;
  assign err_o         = err_q;

endmodule

// File: tb/tb_qtree_lookup_client.sv
// Self-checking bench for qtree_lookup_client: table-driven single lookups plus
// hand-written credit, streaming, orphan, reset and timeout sequences against a scoreboard.
module tb_qtree_lookup_client;
  import qtree_client_pkg::*;

  localparam int DW    = 16;
  localparam int AWD   = 14;
  localparam int TW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready_o;
  logic [DW-1:0]   req_key = '0;
  logic [TW-1:0]   req_tag = '0;
  logic            lookup_en_o;
  logic [DW-1:0]   lookup_data_o;
  logic            lookup_done = 1'b0;
  logic            lookup_match = 1'b0;
  logic [AWD-1:0]  lookup_addr = '0;
  logic [DW-1:0]   lookup_data_in = '0;
  logic            res_valid_o;
  logic            res_ready = 1'b0;
  logic [TW-1:0]   res_tag_o;
  logic            res_match_o;
  logic [AWD-1:0]  res_addr_o;
  logic [DW-1:0]   res_key_o;
  logic [CW-1:0]   inflight_o;
  logic [2:0]      err_o;

  always #5 clk = ~clk;

  qtree_lookup_client #(.D_WIDTH(DW), .A_WIDTH(AWD), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_key_i      (req_key),
    .req_tag_i      (req_tag),
    .lookup_en_o    (lookup_en_o),
    .lookup_data_o  (lookup_data_o),
    .lookup_done_i  (lookup_done),
    .lookup_match_i (lookup_match),
    .lookup_addr_i  (lookup_addr),
    .lookup_data_i  (lookup_data_in),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready),
    .res_tag_o      (res_tag_o),
    .res_match_o    (res_match_o),
    .res_addr_o     (res_addr_o),
    .res_key_o      (res_key_o),
    .inflight_o     (inflight_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic [TW-1:0]  tag;
    logic [DW-1:0]  key;
    logic           match;
    logic [AWD-1:0] addr;
    logic [DW-1:0]  echo;
    logic [2:0]     exp_err;
  } vec_t;

  int total = 0;
  int bad = 0;
  int res_seen = 0;
  int since_rst = 0;
  pending_t  pend_q[$];
  result_t   exp_q[$];
  logic [2:0] exp_err = '0;
  pending_t  mon_p;
  result_t   mon_r;
  vec_t      vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model the pending/result queues from handshakes visible before each rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
      exp_err = '0;
      since_rst = 0;
    end else begin
      since_rst++;
      checkOutput("inflight", 32'(inflight_o), 32'(pend_q.size()));
`ifdef QTREE_CLIENT_TIMEOUT_EN
      checkOutput("err", 32'(err_o & 3'b011), 32'(exp_err));
`else
      checkOutput("err", 32'(err_o), 32'(exp_err));
`endif
      checkOutput("res_valid", 32'(res_valid_o), 32'(exp_q.size() != 0));
      if (since_rst >= 2)
        checkOutput("req_ready", 32'(req_ready_o), 32'((pend_q.size() + exp_q.size()) != DEPTH));
      if (res_valid_o && res_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'(1), 32'(0));
        end else begin
          mon_r = exp_q.pop_front();
          checkOutput("res_tag", 32'(res_tag_o), 32'(mon_r.tag));
          checkOutput("res_match", 32'(res_match_o), 32'(mon_r.match));
          checkOutput("res_addr", 32'(res_addr_o), 32'(mon_r.addr));
          checkOutput("res_key", 32'(res_key_o), 32'(mon_r.key));
          res_seen++;
        end
      end
      if (lookup_done) begin
        if (pend_q.size() == 0) begin
          exp_err[ERR_ORPHAN] = 1'b1;
        end else begin
          mon_p = pend_q.pop_front();
          if (lookup_data_in != mon_p.key) exp_err[ERR_KEY_MISMATCH] = 1'b1;
          mon_r.tag   = mon_p.tag;
          mon_r.match = lookup_match;
          mon_r.addr  = lookup_addr;
          mon_r.key   = mon_p.key;
          exp_q.push_back(mon_r);
        end
      end
      if (req_valid && req_ready_o) begin
        mon_p.tag = req_tag;
        mon_p.key = req_key;
        pend_q.push_back(mon_p);
      end
    end
  end

  task automatic checkResetOutputs(input string tagname);
    checkOutput({tagname, "_req_ready"}, 32'(req_ready_o), 0);
    checkOutput({tagname, "_lookup_en"}, 32'(lookup_en_o), 0);
    checkOutput({tagname, "_lookup_data"}, 32'(lookup_data_o), 0);
    checkOutput({tagname, "_res_valid"}, 32'(res_valid_o), 0);
    checkOutput({tagname, "_res_fields"}, 32'({res_tag_o, res_match_o, res_addr_o} | 32'(res_key_o)), 0);
    checkOutput({tagname, "_inflight"}, 32'(inflight_o), 0);
    checkOutput({tagname, "_err"}, 32'(err_o), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_ready", 32'(req_ready_o), 1);
  endtask

  // One request, one response with the row's match/addr/echo, then one result pop.
  task automatic applyStimulus(input vec_t v);
    checkOutput("row_ready", 32'(req_ready_o), 1);
    req_valid = 1'b1;
    req_tag   = v.tag;
    req_key   = v.key;
    tick();
    req_valid = 1'b0;
    checkOutput("row_lookup_en", 32'(lookup_en_o), 1);
    checkOutput("row_lookup_data", 32'(lookup_data_o), 32'(v.key));
    lookup_done    = 1'b1;
    lookup_match   = v.match;
    lookup_addr    = v.addr;
    lookup_data_in = v.echo;
    tick();
    lookup_done = 1'b0;
    checkOutput("row_lookup_en_pulse", 32'(lookup_en_o), 0);
    checkOutput("row_res_latency", 32'(res_valid_o), 1);
    checkOutput("row_res_key", 32'(res_key_o), 32'(v.key));
    checkOutput("row_err", 32'(err_o), 32'(v.exp_err));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("row_drained", 32'(res_valid_o), 0);
  endtask

  initial begin
    int base;
    vecs[0] = '{tag: 4'h3, key: 16'h1234, match: 1'b1, addr: 14'h00A5, echo: 16'h1234, exp_err: 3'b000};
    vecs[1] = '{tag: 4'hF, key: 16'hFFFF, match: 1'b0, addr: 14'h0000, echo: 16'hFFFF, exp_err: 3'b000};
    vecs[2] = '{tag: 4'h0, key: 16'h0000, match: 1'b1, addr: 14'h3FFF, echo: 16'h0000, exp_err: 3'b000};
    vecs[3] = '{tag: 4'hA, key: 16'hA5A5, match: 1'b1, addr: 14'h1234, echo: 16'hA5A5, exp_err: 3'b000};
    vecs[4] = '{tag: 4'h5, key: 16'h00FF, match: 1'b1, addr: 14'h0010, echo: 16'h00FE, exp_err: 3'b010};

    repeat (2) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();
    checkOutput("release_ready", 32'(req_ready_o), 1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Reset with four lookups outstanding: outputs clear at once, credits come back full.
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(i);
      req_key = 16'h4000 + 16'(i);
      tick();
    end
    req_valid = 1'b0;
    checkOutput("mid_inflight", 32'(inflight_o), 4);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_ready", 32'(req_ready_o), 1);
    checkOutput("mid_inflight_after", 32'(inflight_o), 0);

    // Orphan response with nothing outstanding.
    lookup_done = 1'b1;
    lookup_data_in = 16'h0BAD;
    tick();
    lookup_done = 1'b0;
    tick();
    checkOutput("orphan_err", 32'(err_o), 32'(3'b001));
    checkOutput("orphan_no_result", 32'(res_valid_o), 0);
    checkOutput("orphan_inflight", 32'(inflight_o), 0);
    doReset();

    // Credit stall: eight accepts with results blocked, then a single pop frees one credit.
    res_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_tag = 4'(i);
      req_key = 16'h2000 + 16'(i);
      checkOutput("stall_ready_pre", 32'(req_ready_o), 1);
      tick();
      checkOutput("stall_lookup_en", 32'(lookup_en_o), 1);
      checkOutput("stall_lookup_data", 32'(lookup_data_o), 32'(16'h2000 + 16'(i)));
    end
    req_valid = 1'b0;
    checkOutput("stall_ready_low", 32'(req_ready_o), 0);
    for (int i = 0; i < 8; i++) begin
      lookup_done    = 1'b1;
      lookup_match   = (i % 2 == 1);
      lookup_addr    = 14'(i * 3);
      lookup_data_in = 16'h2000 + 16'(i);
      tick();
      checkOutput("stall_ready_hold", 32'(req_ready_o), 0);
    end
    lookup_done = 1'b0;
    tick();
    checkOutput("stall_ready_still_low", 32'(req_ready_o), 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("stall_ready_back", 32'(req_ready_o), 1);
    res_ready = 1'b1;
    repeat (7) tick();
    res_ready = 1'b0;
    checkOutput("stall_drained", 32'(res_valid_o), 0);

    // Steady state: accept and done every cycle with five lookups in flight.
    base = res_seen;
    res_ready = 1'b1;
    req_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      req_tag = 4'(n);
      req_key = 16'h3000 + 16'(n);
      tick();
    end
    for (int n = 5; n < 25; n++) begin
      req_tag        = 4'(n);
      req_key        = 16'h3000 + 16'(n);
      lookup_done    = 1'b1;
      lookup_match   = 1'b1;
      lookup_addr    = 14'(n);
      lookup_data_in = 16'h3000 + 16'(n - 5);
      tick();
      checkOutput("steady_inflight", 32'(inflight_o), 5);
    end
    req_valid = 1'b0;
    for (int n = 20; n < 25; n++) begin
      lookup_addr    = 14'(n + 100);
      lookup_data_in = 16'h3000 + 16'(n);
      tick();
    end
    lookup_done = 1'b0;
    repeat (3) tick();
    res_ready = 1'b0;
    checkOutput("steady_results", 32'(res_seen - base), 25);
    checkOutput("steady_err", 32'(err_o), 0);
    checkOutput("steady_inflight_end", 32'(inflight_o), 0);

    // A lookup left unanswered: err[2] appears only when the timeout feature is built in.
    req_valid = 1'b1;
    req_tag = 4'h9;
    req_key = 16'h5555;
    tick();
    req_valid = 1'b0;
    repeat (60) tick();
    checkOutput("timeout_early", 32'(err_o[ERR_TIMEOUT]), 0);
    repeat (10) tick();
`ifdef QTREE_CLIENT_TIMEOUT_EN
    checkOutput("timeout_set", 32'(err_o[ERR_TIMEOUT]), 1);
`else
    checkOutput("timeout_absent", 32'(err_o[ERR_TIMEOUT]), 0);
`endif
    checkOutput("timeout_inflight", 32'(inflight_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/qtree_lookup_client.md
Name: qtree_lookup_client

Overview:
- Initiator side of the quadtree lookup interface. Accepts search keys from an upstream valid/ready stream and drives the tree's lookup_en/lookup_data inputs.
- Pairs each in-order lookup_done response with the tag and key of its request. Presents results on a downstream valid/ready stream.
- The tree pipeline has no backpressure, so a credit scheme guarantees every in-flight response has a reserved result slot.

Parameters:
- D_WIDTH, 16, key/data width; must equal the tree's D_WIDTH.
- A_WIDTH, 14, match address width; equals the tree's lookup_addr width, (STAGES+1)*2+clog2(D_CNT).
- TAG_WIDTH, 4, opaque request tag width.
- DEPTH, 8, max outstanding plus buffered results; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_key_i  in  D_WIDTH  search key.
- req_tag_i  in  TAG_WIDTH  request tag.
- lookup_en_o  out  1  lookup strobe to the tree.
- lookup_data_o  out  D_WIDTH  key to the tree.
- lookup_done_i  in  1  tree response strobe.
- lookup_match_i  in  1  match flag from the tree.
- lookup_addr_i  in  A_WIDTH  matched address from the tree.
- lookup_data_i  in  D_WIDTH  key echoed by the tree.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_tag_o  out  TAG_WIDTH  result tag.
- res_match_o  out  1  result match flag.
- res_addr_o  out  A_WIDTH  result address.
- res_key_o  out  D_WIDTH  result key.
- inflight_o  out  clog2(DEPTH)+1  lookups issued but not yet done.
- err_o  out  3  sticky error flags: [0] orphan done, [1] key mismatch, [2] timeout.

Behaviour:
- Reset: every output is 0; both FIFOs empty; inflight is 0; credits equal DEPTH; err is 0. Reset asserted mid-operation discards all outstanding state. Responses arriving after reset release raise err[0].
- Credits: credits = DEPTH - inflight - res_count.
  - req_ready_o = (credits != 0); it is a registered-state function and does not depend on req_valid_i.
  - A request is accepted when req_valid_i && req_ready_o.
- Issue: on accept, lookup_en_o goes to 1 and lookup_data_o takes req_key_i on the next cycle. Both are registered; lookup_en_o is a single-cycle pulse per accept. Back-to-back accepts give consecutive pulses. The {tag, key} pair is pushed into the pending FIFO in the same cycle as the accept.
- Response: on lookup_done_i, pop the pending FIFO and push {tag, lookup_match_i, lookup_addr_i, stored key} into the result FIFO.
  - If lookup_data_i differs from the stored key, set err[1]; the result is still delivered.
  - If lookup_done_i arrives with the pending FIFO empty, set err[0], drop the response and leave counters unchanged.
- inflight: +1 on accept, -1 on a valid done; accept and done in the same cycle leave it unchanged.
- Result FIFO: first-word-fall-through. res_valid_o = not empty. Pop on res_valid_o && res_ready_i. A simultaneous push and pop leaves the count unchanged.
- The credit scheme prevents overflow: inflight + res_count never exceeds DEPTH. Verification asserts this invariant.
- Latency: request accept to lookup_en_o is 1 cycle. lookup_done_i to res_valid_o is 1 cycle when the result FIFO is empty.
- Errors: err bits are sticky and cleared only by reset.

Optional Feature:
- QTREE_CLIENT_TIMEOUT_EN, with an extra parameter TIMEOUT_CYCLES (default 64).
- When defined: a counter resets to 0 on any lookup_done_i or when inflight is 0, and otherwise increments while inflight is nonzero. Reaching TIMEOUT_CYCLES sets err[2], and the counter saturates.
- When undefined: no counter is built and err[2] is tied to 0.

Decomposition:
- Package qtree_client_pkg holds:
  - the pending_t struct {tag, key};
  - the result_t struct {tag, match, addr, key};
  - the error bit index constants ERR_ORPHAN=0, ERR_KEY_MISMATCH=1, ERR_TIMEOUT=2.
- Sub-module qtree_client_fifo: a generic synchronous show-ahead FIFO, parameterised by width and DEPTH, with a count output. It is instantiated twice, once as the pending FIFO and once as the result FIFO.

Test Plan:
- Single lookup: key 0x1234, tag 3. lookup_en_o pulses once with 0x1234. A done with match=1, addr 0x0A5 then yields res_valid with tag 3, match 1, addr 0x0A5, key 0x1234.
- Credit stall: DEPTH=8, res_ready_i=0, 8 requests accepted. req_ready_o goes low after the 8th and stays low. One result pop re-asserts req_ready_o the next cycle.
- Simultaneous accept and done for 20 cycles with res_ready_i=1: inflight holds constant at 5, all 20 results come out in order with correct tags, and err stays 0.
- Orphan done: lookup_done_i pulsed after reset with nothing outstanding. err[0]=1, no result is produced, inflight stays 0.
- Key mismatch: request key 0x00FF, tree echoes 0x00FE. err[1]=1 and the result is still delivered with key 0x00FF.
- Reset mid-stream: rst_n_i asserted with 4 lookups in flight. All outputs go to 0 immediately. After release, req_ready_o=1 with full credits. With QTREE_CLIENT_TIMEOUT_EN defined, a lookup left undone for 64 cycles sets err[2].
